// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types and defaults for the memory-access stage.
//   memState_t          FSM encoding (IDLE, RD_WAIT, WR_WAIT, DONE)
//   ADDR_W_DEF          default MAR / memory address width
//   DATA_W_DEF          default bus / memory data width
//   TIMEOUT_CYCLES_DEF  default wait-state limit (MEM_TIMEOUT_EN builds only)
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } memState_t;

    localparam int ADDR_W_DEF         = 9;
    localparam int DATA_W_DEF         = 32;
    localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: wait-state counter for a pending memory transaction.
// Ports:
//   clock   rising-edge clock
//   clear   synchronous active-high reset
//   start   zero the count (a transaction is being accepted)
//   enable  count this cycle (waiting and no ack)
//   expire  this edge ends the LIMIT-th unacknowledged wait cycle
module mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic start,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (clear || start) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of wait cycles already elapsed, so the
    // LIMIT-th one is the cycle in which count == LIMIT-1.
    assign expire = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage behind the bus mux. Captures
// BusMuxOut into MAR/MDR and runs ready/ack read and write transactions.
// Optional macro MEM_TIMEOUT_EN adds a wait-state timeout that raises err.
// Ports:
//   clock, clear        clock, synchronous active-high reset
//   BusMuxOut           bus value; MARin/MDRin load MAR/MDR (IDLE only)
//   rd_req, wr_req      one-cycle request strobes (read wins if both)
//   mem_rdata, mem_ack  memory read data and completion handshake
//   BusMuxInMDR         MDR value back to the bus mux
//   mem_addr, mem_wdata MAR and MDR driven to memory
//   mem_rd, mem_wr      memory request levels
//   busy, done, err     in-progress, one-cycle completion, timeout flag
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef MEM_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] BusMuxInMDR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    memState_t         state, nextState;
    logic [ADDR_W-1:0] marReg;
    logic [DATA_W-1:0] mdrReg;
    logic              isIdle, waiting, accept, timerExpire;

    assign isIdle  = (state == IDLE);
    assign waiting = (state == RD_WAIT) || (state == WR_WAIT);
    assign accept  = isIdle && (rd_req || wr_req);

`ifdef MEM_TIMEOUT_EN
    logic errReg;

    mem_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) uWaitTimer (
        .clock  (clock),
        .clear  (clear),
        .start  (accept),
        .enable (waiting && !mem_ack),
        .expire (timerExpire)
    );

    // Sticky until the next accepted request; an ack on the expiry edge
    // suppresses expire through the timer's enable, so ack wins.
    always_ff @(posedge clock) begin
        if (clear || accept) begin
            errReg <= 1'b0;
        end else if (timerExpire) begin
            errReg <= 1'b1;
        end
    end
    assign err = errReg;
`else
    assign timerExpire = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (rd_req) begin
                    nextState = RD_WAIT;
                end else if (wr_req) begin
                    nextState = WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack || timerExpire) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // MAR/MDR only follow the bus while idle so that address and write
    // data stay stable for the whole transaction.
    always_ff @(posedge clock) begin
        if (clear) begin
            marReg <= '0;
            mdrReg <= '0;
        end else begin
            if (isIdle && MARin) begin
                marReg <= BusMuxOut[ADDR_W-1:0];
            end
            if (isIdle && MDRin) begin
                mdrReg <= BusMuxOut;
            end else if ((state == RD_WAIT) && mem_ack) begin
                mdrReg <= mem_rdata;
            end
        end
    end

    assign BusMuxInMDR = mdrReg;
    assign mem_addr    = marReg;
    assign mem_wdata   = mdrReg;
    assign mem_rd      = (state == RD_WAIT);
    assign mem_wr      = (state == WR_WAIT);
    assign busy        = !isIdle;
    assign done        = (state == DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they show the state of the cycle that just began.
module tb_mem_access_unit;
    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] BusMuxOut;
    logic        MARin, MDRin, rd_req, wr_req, mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] BusMuxInMDR, mem_wdata;
    logic [8:0]  mem_addr;
    logic        mem_rd, mem_wr, busy, done, err;

    int checks   = 0;
    int failures = 0;
    int rdCnt;
    int wrSeen;

    always #5 clock = ~clock;

    mem_access_unit dut (
        .clock       (clock),
        .clear       (clear),
        .BusMuxOut   (BusMuxOut),
        .MARin       (MARin),
        .MDRin       (MDRin),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .BusMuxInMDR (BusMuxInMDR),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        MARin = 0; MDRin = 0; rd_req = 0; wr_req = 0; mem_ack = 0;
    endtask

    initial begin
        // Reset with garbage on every input.
        clear = 1; BusMuxOut = 32'hFFFF_FFFF; MARin = 1; MDRin = 1;
        rd_req = 1; wr_req = 1; mem_ack = 1; mem_rdata = 32'hA5A5_A5A5;
        tick(); tick();
        check("rst_mem_rd", {31'b0, mem_rd}, 0);
        check("rst_mem_wr", {31'b0, mem_wr}, 0);
        check("rst_busy",   {31'b0, busy},   0);
        check("rst_done",   {31'b0, done},   0);
        check("rst_err",    {31'b0, err},    0);
        check("rst_addr",   {23'b0, mem_addr}, 0);
        check("rst_mdr",    BusMuxInMDR, 0);
        clear = 0; idleInputs();

        // mem_ack while idle is ignored.
        mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        tick(); mem_ack = 0;
        check("idle_ack_busy", {31'b0, busy}, 0);
        check("idle_ack_mdr",  BusMuxInMDR, 0);

        // Basic read, two wait cycles then ack.
        BusMuxOut = 32'h0000_0085; MARin = 1;
        tick(); MARin = 0;
        check("rd_addr", {23'b0, mem_addr}, 32'h085);
        rd_req = 1;
        tick(); rd_req = 0; rdCnt = 0;
        if (mem_rd) rdCnt++;
        check("rd_busy", {31'b0, busy}, 1);
        tick(); if (mem_rd) rdCnt++;
        check("rd_nodone", {31'b0, done}, 0);
        tick(); if (mem_rd) rdCnt++;
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        tick(); mem_ack = 0; if (mem_rd) rdCnt++;
        check("rd_done",  {31'b0, done}, 1);
        check("rd_mdr",   BusMuxInMDR, 32'hDEAD_BEEF);
        tick(); if (mem_rd) rdCnt++;
        check("rd_done_1cyc", {31'b0, done}, 0);
        check("rd_idle",  {31'b0, busy}, 0);
        check("rd_cycles", rdCnt, 3);

        // Write with MDR loaded on the request edge; immediate ack.
        MDRin = 1; BusMuxOut = 32'h1234_5678; wr_req = 1;
        tick(); idleInputs();
        check("wr_mem_wr", {31'b0, mem_wr}, 1);
        check("wr_no_rd",  {31'b0, mem_rd}, 0);
        check("wr_wdata",  mem_wdata, 32'h1234_5678);
        mem_ack = 1;
        tick(); mem_ack = 0;
        check("wr_done", {31'b0, done}, 1);
        tick();
        check("wr_idle", {31'b0, busy}, 0);

        // Busy protection: loads and write request during a read are dropped.
        rd_req = 1;
        tick(); rd_req = 0;
        MARin = 1; MDRin = 1; BusMuxOut = 32'h0000_01FF; wr_req = 1;
        tick(); idleInputs(); wrSeen = 0;
        check("bp_addr", {23'b0, mem_addr}, 32'h085);
        check("bp_mdr",  BusMuxInMDR, 32'h1234_5678);
        check("bp_rd",   {31'b0, mem_rd}, 1);
        for (int i = 0; i < 3; i++) begin
            if (mem_wr) wrSeen++;
            tick();
        end
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        tick(); mem_ack = 0; if (mem_wr) wrSeen++;
        check("bp_done", {31'b0, done}, 1);
        check("bp_mdr_rd", BusMuxInMDR, 32'hCAFE_F00D);
        tick(); if (mem_wr) wrSeen++;
        check("bp_no_wr", wrSeen, 0);
        check("bp_idle", {31'b0, busy}, 0);

        // Upper bus bits are dropped when loading MAR.
        BusMuxOut = 32'hFFFF_F123; MARin = 1;
        tick(); MARin = 0;
        check("mar_trunc", {23'b0, mem_addr}, 32'h123);

        // Simultaneous requests: read wins, then clear aborts mid-read.
        rd_req = 1; wr_req = 1;
        tick(); idleInputs();
        check("pri_rd", {31'b0, mem_rd}, 1);
        check("pri_wr", {31'b0, mem_wr}, 0);
        clear = 1; mem_ack = 1; mem_rdata = 32'h0BAD_0BAD;
        tick(); clear = 0; mem_ack = 0;
        check("abort_busy", {31'b0, busy},   0);
        check("abort_rd",   {31'b0, mem_rd}, 0);
        check("abort_done", {31'b0, done},   0);
        check("abort_mdr",  BusMuxInMDR, 0);
        check("abort_addr", {23'b0, mem_addr}, 0);
        tick();
        check("abort_nodone", {31'b0, done}, 0);

`ifdef MEM_TIMEOUT_EN
        // Never ack: 16 wait cycles, then done with err and MDR untouched.
        MDRin = 1; BusMuxOut = 32'h7777_0001;
        tick(); MDRin = 0;
        rd_req = 1;
        tick(); rd_req = 0;
        for (int i = 1; i < 16; i++) tick();
        check("to_c16_rd",   {31'b0, mem_rd}, 1);
        check("to_c16_done", {31'b0, done},   0);
        tick();
        check("to_done", {31'b0, done}, 1);
        check("to_err",  {31'b0, err},  1);
        check("to_mdr",  BusMuxInMDR, 32'h7777_0001);
        tick();
        check("to_err_sticky", {31'b0, err}, 1);
        // Next request clears err; ack in wait cycle 16 completes normally.
        rd_req = 1;
        tick(); rd_req = 0;
        check("to_err_clr", {31'b0, err}, 0);
        for (int i = 1; i < 16; i++) tick();
        mem_ack = 1; mem_rdata = 32'h0000_1616;
        tick(); mem_ack = 0;
        check("to_ack_done", {31'b0, done}, 1);
        check("to_ack_err",  {31'b0, err},  0);
        check("to_ack_mdr",  BusMuxInMDR, 32'h0000_1616);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-access stage directly downstream of the bus multiplexer: captures BusMuxOut into MAR/MDR and runs read/write transactions against data memory.
- Feeds the MDR value back to the bus mux as its MDR source.
- Uses a ready/ack handshake, so memory may insert wait states.
- Control unit issues one-cycle request strobes and watches busy/done.

Parameters:
- ADDR_W, 9, MAR/memory address width (low bits of BusMuxOut).
- DATA_W, 32, bus and memory data width.
- TIMEOUT_CYCLES, 16, wait-state limit used only when MEM_TIMEOUT_EN is defined.

Ports:
- clock  input  1  single system clock; all state changes on the rising edge.
- clear  input  1  reset, synchronous, active-high.
- BusMuxOut  input  DATA_W  bus value from the bus mux.
- MARin  input  1  load MAR from BusMuxOut[ADDR_W-1:0].
- MDRin  input  1  load MDR from BusMuxOut.
- rd_req  input  1  one-cycle strobe: start memory read.
- wr_req  input  1  one-cycle strobe: start memory write.
- mem_rdata  input  DATA_W  memory read data, valid with mem_ack.
- mem_ack  input  1  memory completion handshake.
- BusMuxInMDR  output  DATA_W  MDR contents to the bus mux.
- mem_addr  output  ADDR_W  current MAR value.
- mem_wdata  output  DATA_W  current MDR value.
- mem_rd  output  1  read request to memory.
- mem_wr  output  1  write request to memory.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  timeout flag.

Behaviour:
- Reset (clear=1 at an edge): state=IDLE; MAR=0, MDR=0; mem_rd=mem_wr=busy=done=err=0. Reset mid-transaction aborts with no MDR update; mem_rd/mem_wr are low from the next cycle.
- FSM states: IDLE, RD_WAIT, WR_WAIT, DONE. All outputs are decoded from registered state or registers.
- IDLE:
  - rd_req -> RD_WAIT.
  - wr_req -> WR_WAIT.
  - rd_req and wr_req together: read wins; the write is dropped.
  - mem_ack is ignored.
- RD_WAIT: mem_rd=1. On mem_ack at an edge: MDR<=mem_rdata, go to DONE.
- WR_WAIT: mem_wr=1, mem_wdata=MDR. On mem_ack: go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Latency:
  - Request at edge n gives mem_rd/mem_wr high during cycle n+1.
  - Earliest ack at edge n+1 gives done during cycle n+2.
  - Minimum transaction is 3 cycles request-to-idle.
- MARin/MDRin are honoured only in IDLE. While busy they are ignored, so address and write data stay stable.
- MDRin and wr_req in the same IDLE cycle: MDR loads at that edge, and the write uses the new value.
- rd_req/wr_req while busy: ignored, not queued.
- MAR takes the low ADDR_W bits; upper bus bits are discarded with no error.
- BusMuxInMDR = MDR at all times (combinational from the register).

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Wait counter clears on entering RD_WAIT/WR_WAIT and increments each wait cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: go to DONE, set err=1, leave MDR unchanged.
  - err is sticky until the next accepted request (cleared on that edge) or clear.
  - Ack on the same edge as the timeout wins: normal completion, err=0.
- Undefined:
  - Waits indefinitely for ack; no counter logic.
  - err port remains and is tied 0.

Decomposition:
- Package cpu_mem_pkg holds: state enum (IDLE, RD_WAIT, WR_WAIT, DONE), ADDR_W/DATA_W defaults, TIMEOUT_CYCLES default.
- One natural sub-module: mem_wait_timer (counter with clear/enable/expire), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Reset: clear=1 for 2 cycles with garbage inputs -> all outputs 0, busy=0.
- Basic read:
  - BusMuxOut=0x0000_0085, MARin=1, then rd_req pulse.
  - Memory acks after 2 wait cycles with mem_rdata=0xDEAD_BEEF.
  - Required: mem_addr=0x085; mem_rd high exactly 3 cycles; done pulse 1 cycle; BusMuxInMDR=0xDEAD_BEEF.
- Write with same-cycle load: MDRin=1, BusMuxOut=0x1234_5678, wr_req=1 together -> mem_wr next cycle, mem_wdata=0x1234_5678; ack immediately -> done 2 cycles after request.
- Busy protection: during RD_WAIT drive MARin=1 with BusMuxOut=0x1FF, MDRin=1, and a wr_req pulse -> mem_addr, MDR and state unchanged; no write ever issued.
- Priority and reset mid-op:
  - rd_req and wr_req together -> only mem_rd asserted.
  - clear during RD_WAIT -> IDLE next cycle, MDR=0, no done pulse.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Never ack -> done and err=1 at wait cycle 16, MDR keeps its prior value.
  - Next rd_req clears err.
  - Ack on cycle 16 -> err=0.
